// File: rtl/alu_rr_scheduler_pkg.sv
// alu_sched_pkg: shared constants and types for the round-robin ALU scheduler.
// Holds ALU opcode encodings, scheduler FSM states and the datapath width.
package alu_sched_pkg;

    localparam int unsigned DATA_W = 16;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } sched_state_e;

endpackage

// File: rtl/alu_rr_scheduler_rr_arbiter.sv
// rr_arbiter: N-way round-robin grant with a rotating priority pointer.
// The grant is combinational (one-hot or zero); the pointer moves past the
// granted requester whenever a grant is issued and holds otherwise.
module rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [N_REQ-1:0] req_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]  gnt_id_o,
    output logic             gnt_any_o
);

    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;

    // Search upward from the pointer (mod N_REQ) for the first valid requester.
    always_comb begin
        gnt_o     = '0;
        gnt_id_o  = '0;
        gnt_any_o = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            sum = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(N_REQ)) begin
                sum = sum - (ID_W+1)'(N_REQ);
            end
            idx = sum[ID_W-1:0];
            if (en_i && !gnt_any_o && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                gnt_id_o   = idx;
                gnt_any_o  = 1'b1;
            end
        end
    end

    // Next pointer: one past the winner, wrapping at N_REQ-1.
    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any_o) begin
            ptr_d = (gnt_id_o == ID_W'(N_REQ - 1)) ? '0 : gnt_id_o + 1'b1;
        end
    end

    // Pointer register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: shares one fixed-latency pipelined ALU between N_REQ
// requesters. Round-robin issue, ID tag pipe aligned to the ALU latency,
// registered response, and a RUN/DRAIN/HALTED quiesce sequence.
// Optional: `define ALU_RR_SCHED_STATS_EN adds stat_issued/stat_stall counters.
module alu_rr_scheduler
    import alu_sched_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned ALU_LAT = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [DATA_W*N_REQ-1:0] req_a,
    input  logic [DATA_W*N_REQ-1:0] req_b,
    input  logic [4*N_REQ-1:0]      req_op,
    output logic [N_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]       alu_a,
    output logic [DATA_W-1:0]       alu_b,
    output logic [3:0]              alu_op,
    input  logic [DATA_W-1:0]       alu_result,
    input  logic                    drain_req,
    output logic                    halted,
`ifdef ALU_RR_SCHED_STATS_EN
    output logic [31:0]             stat_issued,
    output logic [31:0]             stat_stall,
`endif
    output logic                    rsp_valid,
    output logic [ID_W-1:0]         rsp_id,
    output logic [DATA_W-1:0]       rsp_result
);

    sched_state_e state_q, state_d;
    logic         arb_en;

    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_id;
    logic             xfer;

    logic [DATA_W-1:0] a_d, b_d, alu_a_q, alu_b_q;
    logic [3:0]        op_d, alu_op_q;

    logic [ALU_LAT:0]           tag_vld_q, tag_vld_d;
    logic [ALU_LAT:0][ID_W-1:0] tag_id_q, tag_id_d;

    logic              rsp_valid_q;
    logic [ID_W-1:0]   rsp_id_q;
    logic [DATA_W-1:0] rsp_result_q;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .clk_i     (clk),
        .rst_ni    (reset),
        .en_i      (arb_en),
        .req_i     (req_valid),
        .gnt_o     (gnt),
        .gnt_id_o  (gnt_id),
        .gnt_any_o (xfer)
    );

    assign req_ready = gnt;

    // FSM next state; grants only in RUN and masked the cycle drain_req is seen.
    always_comb begin
        state_d = state_q;
        arb_en  = 1'b0;
        halted  = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                arb_en = !drain_req;
                if (drain_req) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!(|tag_vld_q)) state_d = ST_HALTED;
            end
            ST_HALTED: begin
                halted = 1'b1;
                if (!drain_req) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Operand mux: OR of one-hot-selected lanes, so no grant yields an all-zero ADD bubble.
    always_comb begin
        a_d  = '0;
        b_d  = '0;
        op_d = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                a_d  = a_d  | req_a[DATA_W*i +: DATA_W];
                b_d  = b_d  | req_b[DATA_W*i +: DATA_W];
                op_d = op_d | req_op[4*i +: 4];
            end
        end
    end

    // Tag pipe shift: stage 0 loads alongside the ALU input register.
    always_comb begin
        tag_vld_d = {tag_vld_q[ALU_LAT-1:0], xfer};
        tag_id_d  = {tag_id_q[ALU_LAT-1:0], gnt_id};
    end

    // State, ALU input, tag pipe and response registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_RUN;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            tag_vld_q    <= '0;
            tag_id_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
        end else begin
            state_q     <= state_d;
            alu_a_q     <= a_d;
            alu_b_q     <= b_d;
            alu_op_q    <= op_d;
            tag_vld_q   <= tag_vld_d;
            tag_id_q    <= tag_id_d;
            rsp_valid_q <= tag_vld_q[ALU_LAT];
            if (tag_vld_q[ALU_LAT]) begin
                rsp_id_q     <= tag_id_q[ALU_LAT];
                rsp_result_q <= alu_result;
            end
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;

`ifdef ALU_RR_SCHED_STATS_EN
    logic [31:0] stat_issued_q, stat_stall_q;
    logic        stall;

    assign stall = (|req_valid) && !xfer;

    // Saturating transfer and stall counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_issued_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            if (xfer && !(&stat_issued_q)) stat_issued_q <= stat_issued_q + 32'd1;
            if (stall && !(&stat_stall_q)) stat_stall_q <= stat_stall_q + 32'd1;
        end
    end

    assign stat_issued = stat_issued_q;
    assign stat_stall  = stat_stall_q;
`endif

endmodule

// File: doc/alu_rr_scheduler.md
Name: alu_rr_scheduler

Overview:
- Shares one pipelined_alu instance (16-bit A/B, 4-bit alu_op, fixed latency) between N requesters using round-robin arbitration.
- Issues at most one operation per cycle and tags each issued op with its requester ID.
- Returns each result with that ID exactly ALU_LAT cycles after issue.
- Sits between requester engines and the ALU. Supports a drain/halt sequence so software can quiesce the ALU.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester ID width; must equal clog2(N_REQ).
- ALU_LAT, 2, cycles from ALU input capture to valid result (>=1).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset (reset==0 resets on the clk edge)
- req_valid  in  N_REQ  per-requester op valid
- req_a  in  16*N_REQ  operand A, requester i at [16*i+:16]
- req_b  in  16*N_REQ  operand B, same packing
- req_op  in  4*N_REQ  alu_op code, requester i at [4*i+:4]
- req_ready  out  N_REQ  one-hot grant; transfer = req_valid[i] & req_ready[i]
- alu_a  out  16  to ALU A
- alu_b  out  16  to ALU B
- alu_op  out  4  to ALU alu_op
- alu_result  in  16  from ALU result
- drain_req  in  1  level; stop issuing and empty the pipe
- halted  out  1  high in HALTED state
- rsp_valid  out  1  result valid, single-cycle pulse; always accepted, no backpressure
- rsp_id  out  ID_W  requester owning rsp_result
- rsp_result  out  16  ALU result

Behaviour:
- Reset values:
  - req_ready=0; alu_a/alu_b/alu_op=0.
  - rsp_valid=0, rsp_id=0, rsp_result=0; halted=0.
  - RR pointer=0, tag pipe all invalid, state=RUN.
  - Reset mid-operation discards all in-flight tags; late ALU results are never reported.
- Arbitration (RUN only):
  - Grant the first requester with req_valid=1, searching from ptr upward modulo N_REQ.
  - req_ready is combinational, one-hot or zero, and depends only on req_valid, ptr and state.
  - On transfer to requester g: ptr <= (g+1) mod N_REQ. With no transfer, ptr holds.
- Issue:
  - alu_a/alu_b/alu_op are registered. On transfer, latch the granted requester's operands.
  - With no transfer, drive alu_a=0, alu_b=0, alu_op=0 (ADD 0+0, harmless bubble).
- Tag pipe:
  - Shift register of ALU_LAT+1 stages holding {valid, id}.
  - Stage 0 loads {transfer, g} in the same cycle the ALU inputs register.
- Response: when the final stage is valid, register rsp_valid=1, rsp_id=id, rsp_result=alu_result.
- Latency: transfer in cycle t gives rsp_valid in cycle t+ALU_LAT+2 (one cycle for the input register, one for the output register).
- Throughput: one op per cycle sustained. Back-to-back responses keep issue order.
- State machine:
  - RUN: normal issue. drain_req=1 -> DRAIN, with req_ready forced to 0 in the same cycle drain_req is sampled high.
  - DRAIN: no grants. When all tag stages are invalid -> HALTED.
  - HALTED: halted=1, no grants. drain_req=0 -> RUN, with grants resuming the next cycle.
  - DRAIN with drain_req deasserted: stays in DRAIN until the pipe is empty, then HALTED, then RUN.
- Boundaries:
  - Single requester always valid -> granted every cycle.
  - All requesters valid -> strict rotation 0,1,2,3,0...
  - ptr wraps from N_REQ-1 to 0.

Optional Feature:
- Macro ALU_RR_SCHED_STATS_EN.
- Defined: adds outputs stat_issued (32 bits, counts transfers) and stat_stall (32 bits, counts cycles where some req_valid=1 but no transfer occurred, including DRAIN/HALTED).
  - Both are cleared by reset and saturate at all-ones.
- Undefined: ports and counters are absent; the rest of the behaviour is identical.

Decomposition:
- Package alu_sched_pkg holds:
  - the ALU opcode constants (ADD=4'b0000, SUB=4'b0001, AND=4'b0010, OR=4'b0011, XOR=4'b0100);
  - state encodings RUN/DRAIN/HALTED;
  - the 16-bit data width constant.
- One natural sub-module, rr_arbiter: the parameterized N-way round-robin grant plus pointer update, reusable elsewhere.
- Tag pipe and FSM stay in the top level.

Test Plan:
- Single op: requester 0 sends A=10, B=5, op=ADD -> one rsp_valid with rsp_id=0, rsp_result=15, exactly ALU_LAT+2 cycles after transfer.
- Contention: requesters 0..3 all valid with SUB 20-3, AND 6&2, OR 8|1, XOR 9^4 -> grants in order 0,1,2,3; responses 17, 2, 9, 13 with IDs 0..3 on consecutive cycles.
- Fairness: requesters 1 and 3 held valid for 8 cycles -> grants alternate 1,3,1,3; each receives exactly 4.
- Drain: assert drain_req with 3 ops in flight -> req_ready=0 from that cycle, all 3 responses delivered, then halted=1; deassert drain_req -> next grant one cycle later.
- Reset mid-flight: reset=0 for one cycle with 2 ops in flight -> no rsp_valid afterwards; ptr restarts at 0.
- Stats (ALU_RR_SCHED_STATS_EN): 4 transfers plus 2 blocked cycles during DRAIN -> stat_issued=4, stat_stall=2.
